// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: shift-mode encodings and controller states.
package shift_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t SH_LSR = 2'b00;
    localparam shift_mode_t SH_ROR = 2'b01;
    localparam shift_mode_t SH_RRC = 2'b10;
    localparam shift_mode_t SH_ASR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the ALU control FSM (master) and the shift sequencer (slave).
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) ();
    import shift_pkg::*;

    logic             start;
    shift_mode_t      mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, mode, amount, data_in, carry_in,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, mode, amount, data_in, carry_in,
        output busy, done, result, carry_out
    );

endinterface

// File: rtl/shift_step_1b.sv
// Combinational single-bit right shift; the mode selects what enters the MSB.
module shift_step_1b
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  shift_mode_t      mode_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o
);

    logic msb_in;

    always_comb begin
        msb_in = 1'b0;
        case (mode_i)
            SH_ROR:  msb_in = x_i[0];
            SH_RRC:  msb_in = cin_i;
            SH_ASR:  msb_in = x_i[WIDTH-1];
            default: msb_in = 1'b0;
        endcase
    end

    assign f_o    = {msb_in, x_i[WIDTH-1:1]};
    assign cout_o = x_i[0];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle right-shift controller: latches an operand on start, applies one
// shift step per clock, then pulses done with result/carry_out held until the next start.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    shift_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             carry_q, carry_d;
    shift_mode_t      mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] step_f;
    logic             step_cout;
    logic [CNT_W-1:0] amount_sat;

    // Out-of-range amounts saturate to the largest legal shift.
    assign amount_sat = ({1'b0, bus.amount} > (CNT_W+1)'(WIDTH - 1))
                        ? CNT_W'(WIDTH - 1) : bus.amount;

    shift_step_1b #(.WIDTH(WIDTH)) u_step (
        .x_i    (data_q),
        .mode_i (mode_q),
        .cin_i  (carry_q),
        .f_o    (step_f),
        .cout_o (step_cout)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.data_in;
                    carry_d = bus.carry_in;
                    mode_d  = bus.mode;
                    cnt_d   = amount_sat;
                    state_d = (amount_sat != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d  = step_f;
                carry_d = step_cout;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The pulse is registered, so it appears in the cycle after DONE.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            mode_q  <= SH_LSR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = done_q;
    assign bus.result    = data_q;
    assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table plus scoreboard and handshake corner cases.
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    shift_sequencer_if #(.WIDTH(W)) bus ();

    shift_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
    } exp_t;

    typedef struct {
        shift_mode_t  mode;
        logic [W-1:0] data;
        logic         cin;
        logic [2:0]   amt;
        logic [W-1:0] exp_res;
        logic         exp_c;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: view {carry, data} as a W+1 bit word; every mode's carry is
    // its top bit after rotating right by n.
    function automatic exp_t ref_shift(input shift_mode_t m, input logic [W-1:0] x,
                                       input logic c, input int n);
        logic [W:0] r;
        exp_t       e;
        r     = W'(1) == 0 ? '0 : {c, x};
        r     = (W+1)'({r, r} >> n);
        e.c   = r[W];
        case (m)
            SH_LSR:  e.res = x >> n;
            SH_ROR:  e.res = W'({x, x} >> n);
            SH_RRC:  e.res = r[W-1:0];
            default: e.res = W'($signed(x) >>> n);
        endcase
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'd0, bus.done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", {24'd0, bus.result}, {24'd0, e.res});
                check("sb_carry_out", {31'd0, bus.carry_out}, {31'd0, e.c});
            end
        end
    end

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        bus.mode     = v.mode;
        bus.data_in  = v.data;
        bus.carry_in = v.cin;
        bus.amount   = v.amt;
        bus.start    = 1'b1;
        sb_q.push_back('{res: v.exp_res, c: v.exp_c});
        lat = 0; busy_cnt = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                // Scramble operands after acceptance; they must not matter.
                bus.start    = 1'b0;
                bus.data_in  = ~v.data;
                bus.carry_in = ~v.cin;
                bus.amount   = ~v.amt;
                bus.mode     = ~v.mode;
            end
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1;
        end
        check({tag, "_latency"}, lat, 32'(v.amt) + 32'd2);
        check({tag, "_busy_cycles"}, busy_cnt, 32'(v.amt));
    endtask

    vec_t vecs[14];

    initial begin
        exp_t e;
        int   n_done;
        int   cyc;
        bit   prev_done;
        bit   seen;

        vecs[0]  = '{SH_LSR, 8'b10110101, 1'b0, 3'd3, 8'b00010110, 1'b1};
        vecs[1]  = '{SH_ROR, 8'b10110101, 1'b0, 3'd3, 8'b10110110, 1'b1};
        vecs[2]  = '{SH_RRC, 8'b10110101, 1'b0, 3'd2, 8'b10101101, 1'b0};
        vecs[3]  = '{SH_RRC, 8'b10110101, 1'b1, 3'd1, 8'b11011010, 1'b1};
        vecs[4]  = '{SH_ASR, 8'b10110101, 1'b0, 3'd4, 8'b11111011, 1'b0};
        vecs[5]  = '{SH_ASR, 8'b10110101, 1'b1, 3'd0, 8'b10110101, 1'b1};
        vecs[6]  = '{SH_LSR, 8'b10110101, 1'b0, 3'd7, 8'b00000001, 1'b0};
        for (int i = 7; i < 14; i++) begin
            vecs[i].mode = 2'($urandom_range(0, 3));
            vecs[i].data = 8'($urandom);
            vecs[i].cin  = 1'($urandom);
            vecs[i].amt  = (i == 7) ? 3'd7 : 3'($urandom_range(0, 7));
            if (i == 7) vecs[i].mode = SH_RRC;
            e = ref_shift(vecs[i].mode, vecs[i].data, vecs[i].cin, int'(vecs[i].amt));
            vecs[i].exp_res = e.res;
            vecs[i].exp_c   = e.c;
        end

        rst = 1'b1;
        bus.start = 1'b0; bus.mode = SH_LSR; bus.amount = '0;
        bus.data_in = '0; bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", {24'd0, bus.result}, 32'd0);
        check("reset_carry_out", {31'd0, bus.carry_out}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse during SHIFT is ignored; result holds afterwards.
        @(negedge clk);
        bus.mode = SH_LSR; bus.data_in = 8'b10110101; bus.carry_in = 1'b0;
        bus.amount = 3'd3; bus.start = 1'b1;
        sb_q.push_back('{res: 8'b00010110, c: 1'b1});
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.data_in = 8'hFF; bus.amount = 3'd1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            if (bus.done) seen = 1;
        end
        check("ignored_start_done_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        check("held_result", {24'd0, bus.result}, 32'b00010110);
        check("held_carry_out", {31'd0, bus.carry_out}, 32'd1);
        check("held_no_busy", {31'd0, bus.busy}, 32'd0);

        // Start held high: back-to-back ops, one done each, never adjacent.
        e = ref_shift(SH_ASR, 8'h80, 1'b1, 2);
        @(negedge clk);
        bus.mode = SH_ASR; bus.data_in = 8'h80; bus.carry_in = 1'b1;
        bus.amount = 3'd2; bus.start = 1'b1;
        repeat (3) sb_q.push_back(e);
        n_done = 0; cyc = 0; prev_done = 0;
        while (n_done < 3 && cyc < 100) begin
            @(negedge clk); cyc++;
            check("b2b_done_not_adjacent", {31'd0, prev_done & bus.done}, 32'd0);
            prev_done = bus.done;
            if (bus.done) begin
                n_done++;
                if (n_done == 3) bus.start = 1'b0;
            end
        end
        check("b2b_done_count", n_done, 32'd3);
        check("b2b_cycles", cyc, 32'd12);
        repeat (8) @(negedge clk);

        // Reset in the second SHIFT cycle aborts with no done pulse.
        @(negedge clk);
        bus.mode = SH_LSR; bus.data_in = 8'b10110101; bus.carry_in = 1'b1;
        bus.amount = 3'd5; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", {24'd0, bus.result}, 32'd0);
        check("abort_carry_out", {31'd0, bus.carry_out}, 32'd0);
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);

        // Reset and start together: reset wins.
        @(negedge clk);
        bus.mode = SH_ROR; bus.data_in = 8'h5A; bus.amount = 3'd1; bus.carry_in = 1'b1;
        bus.start = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        n_done = 0; cyc = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.busy) cyc++;
        end
        check("rst_start_no_done", n_done, 32'd0);
        check("rst_start_no_busy", cyc, 32'd0);
        check("rst_start_result", {24'd0, bus.result}, 32'd0);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
